gfx_palette_out_stage: RTL and testbench

//  Palette lookup and VGA output stage of the gfx module.
//  - Holds a dual-port colour palette RAM: CPU read/write on the left port, VGA pixel lookup on the right port.
//  - Pipelines the looked-up colour and the sync signals into output latches.
//  - Drives RGB, HSYNC and VSYNC onto tri-stateable pins, as the bus-driver/latch chips did on the board.
//  - Sits between the VGA timing block (pixel/palette/sync/latch strobes) and the DAC/connector.

---
 rtl/gfx_palette_out_stage.sv | 79 +++++++
 tb/tb_gfx_palette_out_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gfx_palette_out_stage.sv
// Palette RAM (CPU read/write + VGA lookup) feeding a two-stage colour/sync latch
// pipeline with tri-stateable RGB and sync pin drivers.
module gfx_palette_out_stage #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cpu_ce_b,
    input  logic                  i_cpu_oe_b,
    input  logic                  i_cpu_rw_b,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    inout  wire  [DATA_WIDTH-1:0] io_cpu_data,
    input  logic                  i_enabled_b,
    input  logic [7:0]            i_pixel,
    input  logic [1:0]            i_palette,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_latch,
    input  logic                  i_out_b,
    output wire  [DATA_WIDTH-1:0] o_rgb,
    output wire                   o_hsync,
    output wire                   o_vsync
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] vga_addr;
    logic                  cpu_we;
    logic                  cpu_rd;

    logic [DATA_WIDTH-1:0] plt_d,   plt_q;
    logic [1:0]            sync1_d, sync1_q;
    logic [DATA_WIDTH-1:0] rgb_d,   rgb_q;
    logic [1:0]            sync_d,  sync_q;

    assign vga_addr = ADDR_WIDTH'({i_palette, i_pixel});
    assign cpu_we   = !i_cpu_ce_b && !i_cpu_rw_b;
    assign cpu_rd   = !i_cpu_ce_b && !i_cpu_oe_b && i_cpu_rw_b;

    always_comb begin
        plt_d   = plt_q;
        sync1_d = sync1_q;
        rgb_d   = rgb_q;
        sync_d  = sync_q;
        if (!i_enabled_b) begin
            plt_d   = mem[vga_addr];
            sync1_d = {i_vsync, i_hsync};
        end
        if (i_latch) begin
            rgb_d  = plt_q;
            sync_d = sync1_q;
        end
    end

    // The lookup reads mem before this edge's CPU write lands, so a same-address
    // collision returns the old entry. The RAM itself is never cleared by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            plt_q   <= '0;
            sync1_q <= '0;
            rgb_q   <= '0;
            sync_q  <= '0;
        end else begin
            plt_q   <= plt_d;
            sync1_q <= sync1_d;
            rgb_q   <= rgb_d;
            sync_q  <= sync_d;
            if (cpu_we)
                mem[i_cpu_addr] <= io_cpu_data;
        end
    end

    assign io_cpu_data         = cpu_rd      ? mem[i_cpu_addr] : {DATA_WIDTH{1'bz}};
    assign o_rgb               = i_out_b     ? {DATA_WIDTH{1'bz}} : rgb_q;
    assign {o_vsync, o_hsync}  = i_enabled_b ? 2'bzz : sync_q;

endmodule

// File: tb/tb_gfx_palette_out_stage.sv
// Bench for gfx_palette_out_stage: directed CPU table, multi-cycle corner sequences,
// then randomized traffic against a rule-level reference model. Undriven pins read as 1 via pullups.
module tb_gfx_palette_out_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce_b = 1'b1, oe_b = 1'b1, rw_b = 1'b1;
    logic [9:0] addr = '0;
    logic       drv = 1'b0;
    logic [7:0] wdata = '0;
    logic       en_b = 1'b0;
    logic [7:0] pix = '0;
    logic [1:0] pal = '0;
    logic       hs = 1'b0, vs = 1'b0, latch = 1'b0, out_b = 1'b0;

    wire  [7:0] cpu_bus;
    wire  [7:0] rgb_w;
    wire        hs_w, vs_w;

    pullup (cpu_bus);
    pullup (rgb_w);
    pullup (hs_w);
    pullup (vs_w);

    assign cpu_bus = drv ? wdata : 8'hzz;

    gfx_palette_out_stage #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .INIT_FILE("")) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_ce_b(ce_b), .i_cpu_oe_b(oe_b), .i_cpu_rw_b(rw_b),
        .i_cpu_addr(addr), .io_cpu_data(cpu_bus),
        .i_enabled_b(en_b), .i_pixel(pix), .i_palette(pal),
        .i_hsync(hs), .i_vsync(vs), .i_latch(latch), .i_out_b(out_b),
        .o_rgb(rgb_w), .o_hsync(hs_w), .o_vsync(vs_w)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: palette contents plus "what the pipeline last sampled / latched".
    logic [7:0] m_mem [1024];
    logic [7:0] m_samp_rgb, m_pin_rgb;
    logic [1:0] m_samp_sync, m_pin_sync;

    always @(posedge clk or posedge rst) begin
        logic [7:0] prev_rgb;
        logic [1:0] prev_sync;
        if (rst) begin
            m_samp_rgb = '0; m_samp_sync = '0; m_pin_rgb = '0; m_pin_sync = '0;
        end else begin
            prev_rgb  = m_samp_rgb;
            prev_sync = m_samp_sync;
            if (!en_b) begin
                m_samp_rgb  = m_mem[{pal, pix}];
                m_samp_sync = {vs, hs};
            end
            if (latch) begin
                m_pin_rgb  = prev_rgb;
                m_pin_sync = prev_sync;
            end
            if (!ce_b && !rw_b) m_mem[addr] = wdata;
        end
    end

    function automatic logic [7:0] exp_bus();
        if (!ce_b && !oe_b && rw_b) return m_mem[addr];
        if (drv)                    return wdata;
        return 8'hFF;
    endfunction

    typedef struct {
        logic       ce_b, oe_b, rw_b;
        logic [9:0] addr;
        logic       drv;
        logic [7:0] wd;
        logic [7:0] exp;
    } cpu_vec_t;

    cpu_vec_t cv [11];

    task automatic cpu_idle();
        ce_b = 1'b1; oe_b = 1'b1; rw_b = 1'b1; drv = 1'b0;
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        ce_b = 1'b0; oe_b = 1'b1; rw_b = 1'b0; addr = a; wdata = d; drv = 1'b1;
    endtask

    initial begin
        cv[0]  = '{1'b0, 1'b1, 1'b0, 10'h123, 1'b1, 8'hA5, 8'hA5};
        cv[1]  = '{1'b0, 1'b0, 1'b1, 10'h123, 1'b0, 8'h00, 8'hA5};
        cv[2]  = '{1'b0, 1'b1, 1'b1, 10'h123, 1'b0, 8'h00, 8'hFF};
        cv[3]  = '{1'b1, 1'b0, 1'b1, 10'h123, 1'b0, 8'h00, 8'hFF};
        cv[4]  = '{1'b0, 1'b0, 1'b0, 10'h124, 1'b1, 8'h5A, 8'h5A};
        cv[5]  = '{1'b0, 1'b0, 1'b1, 10'h124, 1'b0, 8'h00, 8'h5A};
        cv[6]  = '{1'b0, 1'b0, 1'b1, 10'h123, 1'b0, 8'h00, 8'hA5};
        cv[7]  = '{1'b0, 1'b1, 1'b0, 10'h27F, 1'b1, 8'h3C, 8'h3C};
        cv[8]  = '{1'b0, 1'b1, 1'b0, 10'h280, 1'b1, 8'h81, 8'h81};
        cv[9]  = '{1'b0, 1'b1, 1'b0, 10'h010, 1'b1, 8'h11, 8'h11};
        cv[10] = '{1'b0, 1'b1, 1'b0, 10'h033, 1'b1, 8'hFF, 8'hFF};

        // Reset state: enabled pins show zeros
        #3;
        chk("reset_rgb", rgb_w, 8'h00);
        chk("reset_hsync", {7'd0, hs_w}, 8'h00);
        chk("reset_vsync", {7'd0, vs_w}, 8'h00);
        @(negedge clk); rst = 1'b0;

        // CPU port table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ce_b = cv[i].ce_b; oe_b = cv[i].oe_b; rw_b = cv[i].rw_b;
            addr = cv[i].addr; drv = cv[i].drv; wdata = cv[i].wd;
            #2 chk($sformatf("cpu_vec%0d", i), cpu_bus, cv[i].exp);
        end
        @(negedge clk); cpu_idle();

        // Lookup through both stages, then output enables
        pal = 2'd2; pix = 8'h7F; latch = 1'b1; out_b = 1'b0; hs = 1'b1; vs = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("lookup_rgb", rgb_w, 8'h3C);
        chk("lookup_hsync", {7'd0, hs_w}, 8'h01);
        chk("lookup_vsync", {7'd0, vs_w}, 8'h00);
        out_b = 1'b1; #1 chk("rgb_z", rgb_w, 8'hFF);
        en_b = 1'b1;  #1 chk("vsync_z", {7'd0, vs_w}, 8'h01);
        chk("hsync_z", {7'd0, hs_w}, 8'h01);
        en_b = 1'b0; out_b = 1'b0;

        // Latch hold, then single latch pulse
        @(negedge clk); latch = 1'b0; pix = 8'h80;
        repeat (3) @(posedge clk);
        #1 chk("latch_hold", rgb_w, 8'h3C);
        @(negedge clk); latch = 1'b1;
        @(posedge clk); #1 chk("latch_pulse", rgb_w, 8'h81);

        // Same-address collision: lookup sees old data, new data one cycle later
        @(negedge clk); pal = 2'd0; pix = 8'h10;
        @(posedge clk); @(posedge clk);
        @(negedge clk); cpu_write(10'h010, 8'h22);
        @(negedge clk); cpu_idle();
        @(posedge clk); #1 chk("collision_old", rgb_w, 8'h11);
        @(posedge clk); #1 chk("collision_new", rgb_w, 8'h22);

        // Async reset mid-operation; palette survives, writes during reset dropped
        @(negedge clk); pix = 8'h33; hs = 1'b1; vs = 1'b1;
        @(posedge clk); @(posedge clk); #1 chk("pre_reset_rgb", rgb_w, 8'hFF);
        @(negedge clk); #2 rst = 1'b1;
        #1 chk("async_reset_rgb", rgb_w, 8'h00);
        chk("async_reset_sync", {6'd0, vs_w, hs_w}, 8'h00);
        @(negedge clk); cpu_write(10'h033, 8'h00);
        @(posedge clk); @(posedge clk);
        @(negedge clk); cpu_idle(); rst = 1'b0;
        ce_b = 1'b0; oe_b = 1'b0; rw_b = 1'b1; addr = 10'h033;
        #2 chk("palette_survives_reset", cpu_bus, 8'hFF);
        @(negedge clk); cpu_idle();

        // Randomized traffic over 16 initialised entries
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_write({i[3:2], 6'd0, i[1:0]}, 8'($urandom));
            @(negedge clk);
        end
        cpu_idle();
        for (int c = 0; c < 400; c++) begin
            int op;
            @(negedge clk);
            rst   = ($urandom_range(0, 59) == 0);
            op    = $urandom_range(0, 2);
            addr  = {2'($urandom), 6'd0, 2'($urandom)};
            ce_b  = (op == 0) ? 1'($urandom) | 1'b1 : 1'b0;
            oe_b  = 1'($urandom);
            rw_b  = (op != 2);
            drv   = (op == 2);
            wdata = 8'($urandom);
            en_b  = ($urandom_range(0, 3) == 0);
            latch = 1'($urandom);
            out_b = ($urandom_range(0, 3) == 0);
            hs    = 1'($urandom);
            vs    = 1'($urandom);
            pal   = 2'($urandom);
            pix   = {6'd0, 2'($urandom)};
            #2;
            chk("rand_rgb", rgb_w, out_b ? 8'hFF : m_pin_rgb);
            chk("rand_hsync", {7'd0, hs_w}, {7'd0, en_b ? 1'b1 : m_pin_sync[0]});
            chk("rand_vsync", {7'd0, vs_w}, {7'd0, en_b ? 1'b1 : m_pin_sync[1]});
            chk("rand_bus", cpu_bus, exp_bus());
        end

        @(negedge clk); cpu_idle(); rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
